pipe_mult: RTL

//  Parametrised pipelined multiplier with a valid/ready handshake, per-operation signed/unsigned mode,
//  tag passthrough, backpressure and flush. Next generation of the fixed 2-cycle multiplier used by
//  the execute and FPU paths; extra stages give register retiming headroom for Fmax.

---
 rtl/pipe_mult_pkg.sv | 20 ++
 rtl/pipe_mult_stage.sv | 46 ++++
 rtl/pipe_mult.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_mult_pkg.sv
// Shared definitions for the pipelined multiplier: operand mode encoding and
// the default product width / depth used by the FPU configurations.
package pipe_mult_pkg;

    typedef enum logic {
        MULT_UNSIGNED = 1'b0,
        MULT_SIGNED   = 1'b1
    } mult_mode_e;

    localparam int FPU32_WIDTHP = 64;
    localparam int FPU32_STAGES = 2;
    localparam int FPU64_WIDTHP = 128;
    localparam int FPU64_STAGES = 4;

    // Bit prepended to an operand before the signed multiply.
    function automatic logic ext_bit(input logic mode, input logic msb);
        return (mult_mode_e'(mode) == MULT_SIGNED) && msb;
    endfunction

endpackage

// File: rtl/pipe_mult_stage.sv
// One pipeline slice: a valid bit plus a data register that loads together.
// Flush clears the valid bit only; the data register keeps its old contents.
module pipe_mult_stage #(
    parameter int W          = 8,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic         v_in,
    input  logic [W-1:0] d,
    output logic         v,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= v_in;
        end
    end

    // Only the output slice has a reset value; inner slices stay reset-free.
    generate
        if (RESET_DATA) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (load && !flush) begin
                    q <= d;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (load && !flush) begin
                    q <= d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_mult.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control, tag
// passthrough and flush. Stage 0 holds operands, stage 1 the product.
module pipe_mult
    import pipe_mult_pkg::*;
#(
    parameter int WIDTHA = 32,
    parameter int WIDTHB = 32,
    parameter int WIDTHP = FPU32_WIDTHP,
    parameter int STAGES = FPU32_STAGES,
    parameter int TAGW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [WIDTHA-1:0] in_a,
    input  logic [WIDTHB-1:0] in_b,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTHP-1:0] out_p,
    output logic [TAGW-1:0]   out_tag,
    output logic              busy
);

    // Handshake: a transfer happens on any rising edge where valid && ready;
    // valid never waits on ready, and ready here is combinational from out_ready.

    localparam int FULLW = WIDTHA + WIDTHB;
    localparam int OPW   = 1 + TAGW + WIDTHA + WIDTHB;
    localparam int PDW   = TAGW + WIDTHP;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] can_load;
    logic [OPW-1:0]    op_q;
    logic [PDW-1:0]    pd_in [1:STAGES-1];
    logic [PDW-1:0]    pd_q  [1:STAGES-1];

    logic              s0;
    logic [TAGW-1:0]   t0;
    logic [WIDTHA-1:0] a0;
    logic [WIDTHB-1:0] b0;
    logic signed [WIDTHA:0]  ae;
    logic signed [WIDTHB:0]  be;
    logic signed [FULLW-1:0] ax, bx, p_full;
    logic [WIDTHP-1:0] prod;

    // Stage k may load unless it and every stage after it are full and stalled.
    always_comb begin
        can_load = '0;
        for (int k = 0; k < STAGES; k++) begin
            logic [STAGES-1:0] low_mask;
            low_mask    = (STAGES'(1) << k) - STAGES'(1);
            can_load[k] = out_ready || !(&(v | low_mask));
        end
    end

    assign in_ready  = can_load[0];
    assign out_valid = v[STAGES-1];
    assign busy      = |v;
    assign {s0, t0, a0, b0} = op_q;

    always_comb begin
        ae     = $signed({ext_bit(s0, a0[WIDTHA-1]), a0});
        be     = $signed({ext_bit(s0, b0[WIDTHB-1]), b0});
        ax     = FULLW'(ae);
        bx     = FULLW'(be);
        p_full = ax * bx;
    end

    generate
        if (WIDTHP <= FULLW) begin : g_trunc
            assign prod = p_full[WIDTHP-1:0];
        end else begin : g_extend
            assign prod = (mult_mode_e'(s0) == MULT_SIGNED) ? WIDTHP'(p_full)
                                                            : WIDTHP'($unsigned(p_full));
        end
    endgenerate

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_op
                pipe_mult_stage #(.W(OPW), .RESET_DATA(1'b0)) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .flush (flush),
                    .load  (can_load[0]),
                    .v_in  (in_valid),
                    .d     ({in_signed, in_tag, in_a, in_b}),
                    .v     (v[0]),
                    .q     (op_q)
                );
            end else begin : g_pd
                if (k == 1) begin : g_first
                    assign pd_in[k] = {t0, prod};
                end else begin : g_delay
                    assign pd_in[k] = pd_q[k-1];
                end
                pipe_mult_stage #(.W(PDW), .RESET_DATA(k == STAGES - 1)) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .flush (flush),
                    .load  (can_load[k]),
                    .v_in  (v[k-1]),
                    .d     (pd_in[k]),
                    .v     (v[k]),
                    .q     (pd_q[k])
                );
            end
        end
    endgenerate

    assign {out_tag, out_p} = pd_q[STAGES-1];

endmodule
